// File: rtl/aes_key_pkg.sv
// aes_key_pkg: shared constants, rcon table and FSM states for the AES-192 key schedule.
package aes_key_pkg;
  localparam int NK = 6;
  localparam int NR = 12;
  localparam int NUM_STEPS = 8;
  localparam int NUM_RK = 13;
  // Entry k holds rc for step k+1.
  localparam logic [7:0][7:0] RC_TABLE = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
endpackage

// File: rtl/key_expansion_192.sv
// key_expansion_192: maps one 6-word block of the AES-192 schedule to the next 6 words.
module key_expansion_192
  import aes_key_pkg::*;
(
  input  logic [191:0] blk_i,
  input  logic [7:0]   rc_i,
  output logic [191:0] blk_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // Multiplicative inverse as x^254 = prod x^(2^k), k=1..7, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  logic [31:0] acc;
  always_comb begin
    blk_o = '0;
    acc = {sbox(blk_i[23:16]), sbox(blk_i[15:8]), sbox(blk_i[7:0]), sbox(blk_i[31:24])} ^ {rc_i, 24'h0};
    for (int k = 0; k < NK; k++) begin
      acc = acc ^ blk_i[191-32*k -: 32];
      blk_o[191-32*k -: 32] = acc;
    end
  end
endmodule

// File: rtl/key_schedule_192_ctrl.sv
// key_schedule_192_ctrl: expands a 192-bit AES key into 13 round keys, one 6-word step per cycle,
// and serves any round key through a combinational read port.
module key_schedule_192_ctrl
  import aes_key_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [191:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);
  localparam int FLAT_W = (NUM_STEPS + 1) * 192;
  state_t state_q;
  logic [3:0] step_q, prev, idx_c;
  logic busy_q, rk_valid_q;
  logic [191:0] blk_q [NUM_STEPS+1];
  logic [191:0] blk_d;
  logic [FLAT_W-1:0] flat;
  logic [10:0] base;
  assign prev = step_q == 4'd0 ? 4'd0 : step_q - 4'd1;
  key_expansion_192 u_step (
    .blk_i(blk_q[prev]),
    .rc_i (RC_TABLE[prev[2:0]]),
    .blk_o(blk_d)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q <= '0;
      busy_q <= 1'b0;
      rk_valid_q <= 1'b0;
      for (int k = 0; k <= NUM_STEPS; k++) blk_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          blk_q[0] <= key_in;
          step_q <= 4'd1;
          busy_q <= 1'b1;
          rk_valid_q <= 1'b0;
          state_q <= EXPAND;
        end
        EXPAND: begin
          blk_q[step_q] <= blk_d;
          if (step_q == 4'(NUM_STEPS)) begin
            state_q <= DONE;
            busy_q <= 1'b0;
            rk_valid_q <= 1'b1;
          end else begin
            step_q <= step_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Words w0..w53 laid out MSB-first so a round key is one 128-bit slice that may straddle blocks.
  always_comb begin
    flat = '0;
    for (int k = 0; k <= NUM_STEPS; k++) flat[FLAT_W-1-192*k -: 192] = blk_q[k];
  end
  assign idx_c = rk_idx < 4'(NUM_RK) ? rk_idx : 4'd0;
  assign base = 11'(FLAT_W - 1 - 128 * int'(idx_c));
  assign rk_out = (rk_valid_q && rk_idx <= 4'(NR)) ? flat[base -: 128] : '0;
  assign busy = busy_q;
  assign rk_valid = rk_valid_q;
endmodule
